// File: rtl/adc_capture_ctrl.sv
// rtl/adc_capture_ctrl.sv - ADC capture front-end: register, decimate, trigger, buffer, stream out
//
// Registers the ADC bus every clock and derives a sample strobe every decim+1
// clocks. A wrapping counter tracks strobes. After arm, it waits for a trigger
// sample and captures DEPTH strobed samples. It then streams them out oldest
// first over a valid/ready port.
//
// Optional feature macro: ADC_CAP_EDGE_TRIG_EN
//   defined   -> rising-crossing trigger (previous strobe sample below level,
//                current sample at or above level)
//   undefined -> level trigger (sample at or above level)
//
// Ports:
//   clk_pin_p   in   system clock, rising edge
//   rst_pin     in   synchronous active-high reset
//   adc_in      in   raw ADC sample bus
//   decim       in   strobe every decim+1 clocks
//   trig_level  in   unsigned trigger threshold
//   arm         in   start-capture request, honoured in IDLE only
//   led_out     out  last registered ADC sample
//   sample_cnt  out  wrapping strobe count
//   busy        out  high whenever a capture/readout is in progress
//   done        out  one-cycle pulse after the last readout beat
//   rd_valid    out  readout data valid
//   rd_ready    in   readout consumer ready
//   rd_data     out  readout sample, zero while rd_valid is low
module adc_capture_ctrl #(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 16,
    parameter int CNT_W   = 8,
    parameter int DECIM_W = 4
) (
    input  logic               clk_pin_p,
    input  logic               rst_pin,
    input  logic [DATA_W-1:0]  adc_in,
    input  logic [DECIM_W-1:0] decim,
    input  logic [DATA_W-1:0]  trig_level,
    input  logic               arm,
    output logic [DATA_W-1:0]  led_out,
    output logic [CNT_W-1:0]   sample_cnt,
    output logic               busy,
    output logic               done,
    output logic               rd_valid,
    input  logic               rd_ready,
    output logic [DATA_W-1:0]  rd_data
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_CAPTURE,
        S_READOUT
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   adc_q;
    logic [DECIM_W-1:0]  dcnt_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [AW-1:0]       wptr_q, wptr_d;
    logic [AW-1:0]       rptr_q, rptr_d;
    logic                done_q, done_d;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                strobe;
    logic                trig_hit;
    logic                mem_we;
    logic [AW-1:0]       mem_waddr;
    logic                beat;

    // A dcnt left above a freshly lowered decim strobes straight away.
    assign strobe = (dcnt_q >= decim);
    assign beat   = (state_q == S_READOUT) && rd_ready;

`ifdef ADC_CAP_EDGE_TRIG_EN
    logic [DATA_W-1:0] prev_q;

    always_ff @(posedge clk_pin_p) begin
        if (rst_pin) begin
            prev_q <= '0;
        end else if (strobe) begin
            prev_q <= adc_q;
        end
    end

    assign trig_hit = (prev_q < trig_level) && (adc_q >= trig_level);
`else
    assign trig_hit = (adc_q >= trig_level);
`endif

    always_ff @(posedge clk_pin_p) begin
        if (rst_pin) begin
            state_q <= S_IDLE;
            adc_q   <= '0;
            dcnt_q  <= '0;
            cnt_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            adc_q   <= adc_in;
            dcnt_q  <= strobe ? '0 : dcnt_q + DECIM_W'(1);
            if (strobe) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            done_q  <= done_d;
        end
    end

    // Buffer storage is deliberately left out of reset.
    always_ff @(posedge clk_pin_p) begin
        if (mem_we) begin
            mem[mem_waddr] <= adc_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        done_d    = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = wptr_q;
        case (state_q)
            S_IDLE: begin
                if (arm) begin
                    state_d = S_ARMED;
                    wptr_d  = '0;
                end
            end
            S_ARMED: begin
                if (strobe && trig_hit) begin
                    mem_we    = 1'b1;
                    mem_waddr = '0;
                    wptr_d    = AW'(1);
                    state_d   = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (strobe) begin
                    mem_we = 1'b1;
                    wptr_d = wptr_q + AW'(1);
                    if (wptr_q == LAST_IDX) begin
                        state_d = S_READOUT;
                        rptr_d  = '0;
                    end
                end
            end
            S_READOUT: begin
                if (beat) begin
                    rptr_d = rptr_q + AW'(1);
                    if (rptr_q == LAST_IDX) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign led_out    = adc_q;
    assign sample_cnt = cnt_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = done_q;
    assign rd_valid   = (state_q == S_READOUT);
    assign rd_data    = rd_valid ? mem[rptr_q] : '0;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// tb/tb_adc_capture_ctrl.sv - randomized, model-checked bench for adc_capture_ctrl
module tb_adc_capture_ctrl;

    localparam int DATA_W  = 8;
    localparam int DEPTH   = 16;
    localparam int CNT_W   = 8;
    localparam int DECIM_W = 4;

    logic               clk_pin_p = 1'b0;
    logic               rst_pin;
    logic [DATA_W-1:0]  adc_in;
    logic [DECIM_W-1:0] decim;
    logic [DATA_W-1:0]  trig_level;
    logic               arm;
    logic [DATA_W-1:0]  led_out;
    logic [CNT_W-1:0]   sample_cnt;
    logic               busy;
    logic               done;
    logic               rd_valid;
    logic               rd_ready;
    logic [DATA_W-1:0]  rd_data;

    adc_capture_ctrl #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W), .DECIM_W(DECIM_W)
    ) dut (
        .clk_pin_p (clk_pin_p),
        .rst_pin   (rst_pin),
        .adc_in    (adc_in),
        .decim     (decim),
        .trig_level(trig_level),
        .arm       (arm),
        .led_out   (led_out),
        .sample_cnt(sample_cnt),
        .busy      (busy),
        .done      (done),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data)
    );

    always #5 clk_pin_p = ~clk_pin_p;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name, input int cycles);
        total++;
        bad++;
        $display("FAIL %s: no event within %0d cycles", name, cycles);
    endtask

    // Behavioural model: capture list plus a readout index.
    // mode: 0 idle, 1 waiting for trigger, 2 filling, 3 draining
    logic [DATA_W-1:0] m_q;
    int                m_dcnt;
    int                m_cnt;
    int                m_mode;
    int                m_idx;
    logic              m_done;
    logic [DATA_W-1:0] m_prev;
    logic [DATA_W-1:0] cap[$];

    function automatic logic hit(input logic [DATA_W-1:0] s);
`ifdef ADC_CAP_EDGE_TRIG_EN
        return (m_prev < trig_level) && (s >= trig_level);
`else
        return (s >= trig_level);
`endif
    endfunction

    task automatic model_update();
        logic              stb;
        logic [DATA_W-1:0] s;
        if (rst_pin) begin
            m_q = '0; m_dcnt = 0; m_cnt = 0; m_mode = 0; m_idx = 0;
            m_done = 1'b0; m_prev = '0; cap.delete();
        end else begin
            stb    = (m_dcnt >= int'(decim));
            s      = m_q;
            m_done = 1'b0;
            case (m_mode)
                0: if (arm) begin m_mode = 1; cap.delete(); end
                1: if (stb && hit(s)) begin cap.push_back(s); m_mode = 2; end
                2: if (stb) begin
                       cap.push_back(s);
                       if (cap.size() == DEPTH) begin m_mode = 3; m_idx = 0; end
                   end
                3: if (rd_ready) begin
                       m_idx++;
                       if (m_idx == DEPTH) begin m_mode = 0; m_done = 1'b1; end
                   end
                default: m_mode = 0;
            endcase
            if (stb) begin
                m_cnt  = (m_cnt + 1) % (1 << CNT_W);
                m_dcnt = 0;
                m_prev = s;
            end else begin
                m_dcnt++;
            end
            m_q = adc_in;
        end
    endtask

    // Compare process plus beat/done collection.
    logic              chk_en = 1'b0;
    logic              prev_stall = 1'b0;
    logic [DATA_W-1:0] prev_data = '0;
    logic [DATA_W-1:0] beats[$];
    int                done_cnt = 0;

    always @(negedge clk_pin_p) begin
        if (chk_en) begin
            logic              ev;
            logic [DATA_W-1:0] ed;
            ev = (m_mode == 3);
            ed = ev ? cap[m_idx] : '0;
            chk("led_out", 64'(led_out), 64'(m_q));
            chk("sample_cnt", 64'(sample_cnt), 64'(m_cnt));
            chk("busy", 64'(busy), 64'(m_mode != 0));
            chk("done", 64'(done), 64'(m_done));
            chk("rd_valid", 64'(rd_valid), 64'(ev));
            chk("rd_data", 64'(rd_data), 64'(ed));
            if (prev_stall && rd_valid) chk("stall_hold", 64'(rd_data), 64'(prev_data));
            if (rd_valid && rd_ready) beats.push_back(rd_data);
            if (done) done_cnt++;
            prev_stall = rd_valid && !rd_ready;
            prev_data  = rd_data;
        end
    end

    // Stimulus drivers. adc_mode: 0 hold, 1 ramp, 2 random.
    // rdy_mode: 0 always, 1 pattern 1,0,0, 2 random, 3 held low.
    int adc_mode = 0;
    int rdy_mode = 0;
    int cyc      = 0;
    logic rand_ctl = 1'b0;

    task automatic tick();
        @(posedge clk_pin_p);
        model_update();
        #1;
        arm = 1'b0;
        cyc++;
        case (adc_mode)
            1: adc_in = adc_in + 8'd1;
            2: adc_in = DATA_W'($urandom);
            default: ;
        endcase
        case (rdy_mode)
            0: rd_ready = 1'b1;
            1: rd_ready = (cyc % 3 == 0);
            2: rd_ready = ($urandom_range(0, 2) != 0);
            default: rd_ready = 1'b0;
        endcase
        if (rand_ctl) begin
            arm     = ($urandom_range(0, 19) == 0);
            rst_pin = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 49) == 0) decim = DECIM_W'($urandom_range(0, 3));
            if ($urandom_range(0, 99) == 0) trig_level = DATA_W'($urandom);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_done(input string name, input int budget);
        int start;
        int n;
        start = done_cnt;
        n = 0;
        while (done_cnt == start && n < budget) begin
            tick();
            n++;
        end
        if (done_cnt == start) timeout_fail(name, budget);
    endtask

    task automatic start_capture(input logic [DECIM_W-1:0] d, input logic [DATA_W-1:0] lvl);
        decim      = d;
        trig_level = lvl;
        adc_in     = '0;
        beats.delete();
        arm        = 1'b1;
    endtask

    initial begin
        int n;
        int d0;
        logic [CNT_W-1:0] c0;
        rst_pin = 1'b1; adc_in = '0; decim = '0; trig_level = '0; arm = 1'b0; rd_ready = 1'b0;
        ticks(3);
        chk_en  = 1'b1;
        rst_pin = 1'b0;

        // Ramp capture, one strobe per clock.
        adc_mode = 1; rdy_mode = 0;
        start_capture(4'd0, 8'd5);
        d0 = done_cnt;
        wait_done("t2_done", 200);
        ticks(5);
        chk("t2_done_pulses", 64'(done_cnt - d0), 64'd1);
        chk("t2_beats", 64'(beats.size()), 64'(DEPTH));
        for (int i = 0; i < DEPTH && i < beats.size(); i++)
            chk("t2_beat_val", 64'(beats[i]), 64'(5 + i));

        // Reset held mid-capture.
        start_capture(4'd0, 8'd5);
        ticks(12);
        chk("t1_busy_before", 64'(busy), 64'd1);
        rst_pin = 1'b1;
        ticks(3);
        chk("t1_led", 64'(led_out), 64'd0);
        chk("t1_cnt", 64'(sample_cnt), 64'd0);
        chk("t1_busy", 64'(busy), 64'd0);
        chk("t1_done", 64'(done), 64'd0);
        chk("t1_valid", 64'(rd_valid), 64'd0);
        chk("t1_data", 64'(rd_data), 64'd0);
        rst_pin = 1'b0;
        start_capture(4'd0, 8'd5);
        tick();
        chk("t1_rearm_busy", 64'(busy), 64'd1);
        wait_done("t1_done_after", 200);
        chk("t1_beat0", 64'(beats.size() > 0 ? beats[0] : 8'hxx), 64'd5);

        // Decimation by 4.
        start_capture(4'd3, 8'd5);
        ticks(4);
        c0 = sample_cnt;
        ticks(8);
        chk("t3_rate", 64'(CNT_W'(sample_cnt - c0)), 64'd2);
        wait_done("t3_done", 400);
        chk("t3_beats", 64'(beats.size()), 64'(DEPTH));
        if (beats.size() > 0) begin
            chk("t3_first_lo", 64'(beats[0] >= 8'd5), 64'd1);
            chk("t3_first_hi", 64'(beats[0] <= 8'd8), 64'd1);
        end
        for (int i = 1; i < beats.size(); i++)
            chk("t3_step", 64'(DATA_W'(beats[i] - beats[i-1])), 64'd4);

        // Readout backpressure.
        rdy_mode = 1;
        start_capture(4'd0, 8'd5);
        wait_done("t4_done", 300);
        chk("t4_beats", 64'(beats.size()), 64'(DEPTH));
        for (int i = 0; i < DEPTH && i < beats.size(); i++)
            chk("t4_beat_val", 64'(beats[i]), 64'(5 + i));
        rdy_mode = 0;

        // Counter wrap.
        decim = '0;
        n = 0;
        while (sample_cnt != 8'hFF && n < 400) begin tick(); n++; end
        if (sample_cnt != 8'hFF) timeout_fail("t5_reach_ff", 400);
        tick();
        chk("t5_wrap", 64'(sample_cnt), 64'd0);

        // Arm during readout is ignored.
        rdy_mode = 3;
        start_capture(4'd0, 8'd1);
        n = 0;
        while (!rd_valid && n < 400) begin tick(); n++; end
        if (!rd_valid) timeout_fail("t5_reach_readout", 400);
        arm = 1'b1;
        ticks(4);
        chk("t5_busy_hold", 64'(busy), 64'd1);
        chk("t5_valid_hold", 64'(rd_valid), 64'd1);
        rdy_mode = 0;
        wait_done("t5_done", 100);
        chk("t5_beats", 64'(beats.size()), 64'(DEPTH));
        ticks(3);
        chk("t5_idle_after", 64'(busy), 64'd0);

        // Trigger mode with a sample held above the level at arm time.
        adc_mode = 0; decim = '0; trig_level = 8'h40; adc_in = 8'h80;
        ticks(5);
        beats.delete();
        arm = 1'b1;
`ifdef ADC_CAP_EDGE_TRIG_EN
        ticks(10);
        chk("t6_no_trig_busy", 64'(busy), 64'd1);
        chk("t6_no_trig_valid", 64'(rd_valid), 64'd0);
        adc_in = 8'h10;
        ticks(5);
        adc_in = 8'h50;
        wait_done("t6_done", 100);
        chk("t6_first", 64'(beats.size() > 0 ? beats[0] : 8'hxx), 64'h50);
`else
        wait_done("t6_done", 100);
        chk("t6_first", 64'(beats.size() > 0 ? beats[0] : 8'hxx), 64'h80);
`endif
        chk("t6_beats", 64'(beats.size()), 64'(DEPTH));

        // Randomized phase against the model.
        adc_mode = 2; rdy_mode = 2; rand_ctl = 1'b1;
        ticks(3000);
        rand_ctl = 1'b0;
        rst_pin  = 1'b0;
        ticks(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
